tdc_packetizer: RTL and testbench
=================================

Name: tdc_packetizer

Overview:
- Downstream of the TDC core (time_counter / frac_sync / int_sync / mlt_x400 chain).
- Captures each 37-bit timestamp qualified by its data-valid strobe into a small FIFO.
- Serialises each timestamp into a fixed 7-byte framed packet on a byte stream with valid/ready handshake, for the UART/USB transmitter.
- Tracks and reports dropped timestamps when the FIFO is full.

Parameters:
- FIFO_DEPTH, 8: timestamp FIFO entries; power of 2, minimum 2.
- SYNC_BYTE, 8'hA5: packet header byte.
- DROP_W, 16: drop counter width.

Ports:
- pll_clk  in  1  clock; same domain as the TDC result output.
- rst  in  1  reset, asynchronous, active-low.
- time_in  in  37  timestamp from TDC core.
- time_dval  in  1  one-cycle strobe; time_in valid.
- tx_data  out  8  packet byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries stored; excludes the packet in flight.
- drop_cnt  out  DROP_W  dropped timestamps; saturating.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst=0): FIFO emptied; FSM to IDLE; tx_data=0, tx_valid=0, fifo_level=0, drop_cnt=0, busy=0, ovf flag=0.
- Reset mid-packet aborts the packet immediately; no partial resume.
- FIFO write: on a pll_clk edge with time_dval=1.
  - Accepted if not full, or if full and a pop occurs on the same edge (level unchanged).
  - Otherwise dropped: drop_cnt += 1, saturating at all-ones; sticky ovf flag set.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head entry into a 40-bit shift register, latch and clear ovf, go to LOAD.
  - LOAD: build the packet, set byte index=0, go to SEND.
  - SEND: present the current byte with tx_valid=1.
    - On tx_valid & tx_ready the index increments.
    - After byte 6 is accepted, go to IDLE.
- Packet byte order:
  - byte0: SYNC_BYTE.
  - byte1: {ovf, 2'b00, t[36:32]}.
  - byte2: t[31:24].
  - byte3: t[23:16].
  - byte4: t[15:8].
  - byte5: t[7:0].
  - byte6: XOR of bytes 1..5.
- Handshake:
  - tx_data and tx_valid hold stable while tx_valid=1 and tx_ready=0.
  - tx_valid never drops mid-packet.
  - tx_ready is ignored when tx_valid=0.
- ovf flag:
  - Latching into a packet clears ovf.
  - A drop on the same edge as the latch leaves ovf=1 for the next packet.
- Latency: time_dval sampled at edge k into an empty FIFO in IDLE; pop at edge k+1; LOAD→SEND at k+2; tx_valid=1 with byte0 visible after edge k+2.
- Throughput: with tx_ready held 1 and FIFO non-empty, 7 bytes per packet then IDLE+LOAD gap. tx_valid=0 for exactly 2 cycles between back-to-back packets (9-cycle period).
- fifo_level is a registered count; busy=1 in LOAD and SEND.

Test Plan:
- Single timestamp, tx_ready=1: time_in=37'h12_3456_789A, one dval → tx_valid after 2 edges; bytes A5,12,34,56,78,9A,92; then tx_valid=0; drop_cnt=0.
- Backpressure: same stimulus, tx_ready toggled 1,0,0,1,... → byte sequence identical; tx_data stable during stalls; no byte skipped or repeated.
- Overflow, FIFO_DEPTH=8, tx_ready=0, 10 consecutive dvals with distinct values:
  - Expected after stimulus: first value in flight, fifo_level=8, drop_cnt=1.
  - After release: packet 2 byte1 bit7=1; packets 1 and 3–9 bit7=0; 9 packets total.
- Full plus simultaneous pop:
  - Setup: FIFO full; dval on the same edge a packet load pops.
  - Expected: write accepted, fifo_level stays 8, drop_cnt unchanged.
- Back-to-back: 3 dvals 1 cycle apart, tx_ready=1 → 3 packets, 9-cycle period, tx_valid low exactly 2 cycles between packets; checksums correct.
- Reset mid-packet:
  - Stimulus: rst=0 asynchronously after byte2 accepted, with 2 entries queued.
  - Expected: tx_valid, fifo_level and drop_cnt drop to 0 immediately.
  - After release: no output until a new dval.

Source files
------------

// File: rtl/tdc_packetizer.sv
// Buffers 37-bit TDC timestamps in a small FIFO and frames each one as a 7-byte
// packet (sync, flags + 5 timestamp bytes, XOR checksum) on a valid/ready byte stream.
module tdc_packetizer #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         DROP_W     = 16
) (
  input  logic                          pll_clk,
  input  logic                          rst,
  input  logic [36:0]                   time_in,
  input  logic                          time_dval,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_W-1:0]             drop_cnt,
  output logic                          busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  // Handshake: a byte moves on a pll_clk edge where tx_valid & tx_ready. Once tx_valid
  // rises it stays high until the checksum byte moves, tx_data is held while stalled,
  // and tx_ready is a don't-care whenever tx_valid is low.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [36:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          ovf;
  logic [39:0]   shreg;
  logic [7:0]    chk;
  logic [2:0]    idx;

  logic full, pop, push, drop, accept, last;

  assign full   = (level == LW'(FIFO_DEPTH));
  assign pop    = (state == IDLE) && (level != '0);
  assign push   = time_dval && (!full || pop);
  assign drop   = time_dval && full && !pop;
  assign accept = tx_valid && tx_ready;
  assign last   = (idx == 3'd6);

  assign fifo_level = level;
  assign tx_valid   = (state == SEND);
  assign busy       = (state != IDLE);

  // Storage needs no reset: only entries counted by level are ever read.
  always_ff @(posedge pll_clk) begin
    if (push) mem[wr_ptr] <= time_in;
  end

  always_ff @(posedge pll_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
      // A drop on the latching edge wins so the loss is flagged in the next packet.
      if (drop)     ovf <= 1'b1;
      else if (pop) ovf <= 1'b0;
    end
  end

  always_ff @(posedge pll_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (level != '0) state_nxt = LOAD;
      LOAD:    state_nxt = SEND;
      SEND:    if (accept && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // shreg[39:32] always holds the next data byte; it advances once bytes 1..5 go out.
  always_ff @(posedge pll_clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      chk   <= '0;
      idx   <= '0;
    end else begin
      if (pop) shreg <= {ovf, 2'b00, mem[rd_ptr]};
      if (state == LOAD) begin
        chk <= shreg[39:32] ^ shreg[31:24] ^ shreg[23:16] ^ shreg[15:8] ^ shreg[7:0];
        idx <= 3'd0;
      end else if ((state == SEND) && accept) begin
        idx <= idx + 3'd1;
        if (idx != 3'd0) shreg <= {shreg[31:0], 8'h00};
      end
    end
  end

  always_comb begin
    tx_data = '0;
    if (state == SEND) begin
      case (idx)
        3'd0:    tx_data = SYNC_BYTE;
        3'd6:    tx_data = chk;
        default: tx_data = shreg[39:32];
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_packetizer.sv
// Bench for tdc_packetizer: directed packet table, overflow, full-with-pop, back-to-back,
// mid-packet reset, drop saturation and random traffic against a queue-based packet model.
module tb_tdc_packetizer;
  localparam int         DEPTH = 8;
  localparam int         DW    = 4;
  localparam logic [7:0] SYNC  = 8'hA5;
  localparam int         LW    = $clog2(DEPTH) + 1;

  logic          pll_clk, rst;
  logic [36:0]   time_in;
  logic          time_dval;
  logic [7:0]    tx_data;
  logic          tx_valid, tx_ready;
  logic [LW-1:0] fifo_level;
  logic [DW-1:0] drop_cnt;
  logic          busy;

  tdc_packetizer #(.FIFO_DEPTH(DEPTH), .SYNC_BYTE(SYNC), .DROP_W(DW)) dut (
    .pll_clk    (pll_clk),
    .rst        (rst),
    .time_in    (time_in),
    .time_dval  (time_dval),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  // clock / watchdog
  initial begin
    pll_clk = 1'b0;
    forever #5 pll_clk = ~pll_clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q[$];   // scoreboard: bytes the model says will be accepted
  logic [7:0]  rx_q[$];    // every byte accepted by the sink
  bit          vhist[$];   // tx_valid per sampled cycle

  // packet-level reference model
  logic [36:0] m_q[$];     // timestamps waiting
  logic [7:0]  m_pend[$];  // bytes of the packet currently on the stream
  logic [7:0]  m_next[$];  // packet built on the latching edge, visible one edge later
  bit          m_loading;
  bit          m_ovf;
  int          m_drops;

  typedef struct packed {
    logic [36:0]     t;
    logic            stall;
    logic [6:0][7:0] b;    // b[0] is the first byte on the wire
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_pend.delete();
    m_next.delete();
    exp_q.delete();
    m_loading = 1'b0;
    m_ovf     = 1'b0;
    m_drops   = 0;
  endfunction

  function automatic void make_packet(input logic [36:0] t, input bit ovf);
    logic [7:0] b[7];
    b[0] = SYNC;
    b[1] = {ovf, 2'b00, t[36:32]};
    b[2] = t[31:24];
    b[3] = t[23:16];
    b[4] = t[15:8];
    b[5] = t[7:0];
    b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
    m_next.delete();
    for (int i = 0; i < 7; i++) begin
      m_next.push_back(b[i]);
      exp_q.push_back(b[i]);
    end
  endfunction

  // Advance the model across one clock edge with the given inputs.
  function automatic void model_edge(input bit dval, input logic [36:0] t, input bit ready);
    bit idle, take, full, drop;
    if (!rst) begin
      model_reset();
      return;
    end
    idle = (m_pend.size() == 0) && !m_loading;
    take = idle && (m_q.size() > 0);
    full = (m_q.size() == DEPTH);
    drop = dval && full && !take;
    if ((m_pend.size() > 0) && ready) void'(m_pend.pop_front());
    if (m_loading) begin
      m_pend    = m_next;
      m_loading = 1'b0;
    end
    if (take) begin
      make_packet(m_q.pop_front(), m_ovf);
      m_loading = 1'b1;
    end
    if (drop) begin
      m_ovf = 1'b1;
      if (m_drops < (1 << DW) - 1) m_drops++;
    end else if (take) begin
      m_ovf = 1'b0;
    end
    if (dval && !drop) m_q.push_back(t);
  endfunction

  task automatic compare_outputs();
    check("tx_valid", tx_valid, m_pend.size() > 0);
    if (m_pend.size() > 0) check("tx_data", tx_data, m_pend[0]);
    check("fifo_level", fifo_level, m_q.size());
    check("drop_cnt", drop_cnt, m_drops);
    check("busy", busy, (m_pend.size() > 0) || m_loading);
  endtask

  // driver: one cycle, inputs applied after the falling edge, outputs sampled 1ns later
  task automatic step(input bit dval, input logic [36:0] t, input bit ready);
    @(negedge pll_clk);
    time_dval = dval;
    time_in   = t;
    tx_ready  = ready;
    #1;
    compare_outputs();
    if (rst && tx_valid && tx_ready) begin
      rx_q.push_back(tx_data);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got byte %0h expected none", tx_data);
      end else begin
        check("sb_byte", tx_data, exp_q.pop_front());
      end
    end
    vhist.push_back(tx_valid);
    model_edge(dval, t, ready);
  endtask

  task automatic reset_zero_checks();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_busy", busy, 0);
  endtask

  task automatic release_reset();
    @(negedge pll_clk);
    rst       = 1'b1;
    time_dval = 1'b0;
    #1;
    compare_outputs();
    model_edge(1'b0, '0, tx_ready);
  endtask

  task automatic apply_reset();
    @(negedge pll_clk);
    #3;
    time_dval = 1'b0;
    rst       = 1'b0;
    #1;
    reset_zero_checks();
    model_reset();
    repeat (2) step(1'b0, '0, 1'b1);
    release_reset();
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (((m_pend.size() > 0) || m_loading || (m_q.size() > 0)) && (n < max_cycles)) begin
      step(1'b0, '0, 1'b1);
      n++;
    end
    checks++;
    if (n >= max_cycles) begin
      errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles", n);
    end
    step(1'b0, '0, 1'b1);
  endtask

  function automatic logic [36:0] rand_time();
    return {5'($urandom_range(0, 31)), 32'($urandom)};
  endfunction

  initial begin
    int base, c, first, n, nr;
    int rises[$];
    logic [7:0] b1;
    rst       = 1'b0;
    time_dval = 1'b0;
    time_in   = '0;
    tx_ready  = 1'b0;
    model_reset();

    vecs[0] = '{t: 37'h12_3456_789A, stall: 1'b0, b: {8'h92, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12, 8'hA5}};
    vecs[1] = '{t: 37'h12_3456_789A, stall: 1'b1, b: {8'h92, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12, 8'hA5}};
    vecs[2] = '{t: 37'h1F_FFFF_FFFF, stall: 1'b0, b: {8'h1F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F, 8'hA5}};
    vecs[3] = '{t: 37'h00_0000_0000, stall: 1'b1, b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5}};
    vecs[4] = '{t: 37'h01_0203_0405, stall: 1'b0, b: {8'h01, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'hA5}};
    vecs[5] = '{t: 37'h10_8000_0001, stall: 1'b1, b: {8'h91, 8'h01, 8'h00, 8'h00, 8'h80, 8'h10, 8'hA5}};

    // reset state
    repeat (2) @(negedge pll_clk);
    #1;
    reset_zero_checks();
    release_reset();
    repeat (3) step(1'b0, '0, 1'b1);

    // table: one timestamp per entry, optional 1,0,0 ready pattern
    for (int v = 0; v < 6; v++) begin
      base  = rx_q.size();
      first = -1;
      step(1'b1, vecs[v].t, 1'b1);
      c = 1;
      while ((rx_q.size() < base + 7) && (c < 100)) begin
        step(1'b0, '0, vecs[v].stall ? (c % 3 == 0) : 1'b1);
        if ((first < 0) && tx_valid) first = c;
        c++;
      end
      check("vec_latency", first, 3);
      check("vec_count", rx_q.size() - base, 7);
      for (int i = 0; i < 7; i++)
        if (base + i < rx_q.size()) check("vec_byte", rx_q[base + i], vecs[v].b[i]);
      repeat (2) step(1'b0, '0, 1'b1);
      check("vec_idle", tx_valid, 0);
      check("vec_drops", drop_cnt, 0);
    end

    // overflow: ten timestamps into a stalled sink
    base = rx_q.size();
    for (int i = 0; i < 10; i++) step(1'b1, 37'h0A_0000_0000 + 37'(i), 1'b0);
    step(1'b0, '0, 1'b0);
    check("ovf_level", fifo_level, 8);
    check("ovf_drops", drop_cnt, 1);
    check("ovf_inflight_valid", tx_valid, 1);
    check("ovf_inflight_data", tx_data, SYNC);
    drain(300);
    check("ovf_packets", (rx_q.size() - base) / 7, 9);
    for (int p = 0; p < 9; p++) begin
      if (base + 7 * p + 1 < rx_q.size()) begin
        b1 = rx_q[base + 7 * p + 1];
        check("ovf_bit7", b1[7], p == 1);
      end
    end

    // full FIFO with a write on the same edge as the pop
    for (int i = 0; i < 9; i++) step(1'b1, 37'h0B_0000_0000 + 37'(i), 1'b0);
    base = rx_q.size();
    n = 0;
    while ((rx_q.size() < base + 7) && (n < 50)) begin
      step(1'b0, '0, 1'b1);
      n++;
    end
    step(1'b1, 37'h0B_0000_00FF, 1'b1);
    check("fullpop_idle_level", fifo_level, 8);
    step(1'b0, '0, 1'b1);
    check("fullpop_level", fifo_level, 8);
    check("fullpop_drops", drop_cnt, 1);
    check("fullpop_busy", busy, 1);
    drain(300);

    // back-to-back packets
    vhist.delete();
    step(1'b1, 37'h01_1111_1111, 1'b1);
    step(1'b1, 37'h02_2222_2222, 1'b1);
    step(1'b1, 37'h03_3333_3333, 1'b1);
    repeat (35) step(1'b0, '0, 1'b1);
    rises.delete();
    for (int i = 1; i < vhist.size(); i++)
      if (vhist[i] && !vhist[i - 1]) rises.push_back(i);
    nr = rises.size();
    check("b2b_rises", nr, 3);
    if (nr >= 3) begin
      check("b2b_first", rises[0], 3);
      check("b2b_period1", rises[1] - rises[0], 9);
      check("b2b_period2", rises[2] - rises[1], 9);
      n = 0;
      for (int i = rises[0]; i < rises[1]; i++) n += vhist[i];
      check("b2b_high_cycles", n, 7);
    end

    // reset in the middle of a packet with two entries queued
    base = rx_q.size();
    step(1'b1, 37'h05_0000_0001, 1'b1);
    step(1'b1, 37'h05_0000_0002, 1'b1);
    step(1'b1, 37'h05_0000_0003, 1'b1);
    n = 0;
    while ((rx_q.size() < base + 3) && (n < 20)) begin
      step(1'b0, '0, 1'b1);
      n++;
    end
    @(negedge pll_clk);
    time_dval = 1'b0;
    tx_ready  = 1'b1;
    #1;
    check("midrst_pre_valid", tx_valid, 1);
    check("midrst_pre_level", fifo_level, 2);
    check("midrst_pre_drops", drop_cnt, 1);
    #1;
    rst = 1'b0;
    #1;
    reset_zero_checks();
    model_reset();
    repeat (3) step(1'b0, '0, 1'b1);
    release_reset();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, 1'b1);
      n += tx_valid;
    end
    check("midrst_quiet", n, 0);
    base = rx_q.size();
    step(1'b1, 37'h12_3456_789A, 1'b1);
    drain(50);
    check("midrst_new_packet", rx_q.size() - base, 7);
    if (rx_q.size() >= base + 7) check("midrst_chk", rx_q[base + 6], 8'h92);

    // drop counter saturation
    for (int i = 0; i < 40; i++) step(1'b1, rand_time(), 1'b0);
    step(1'b0, '0, 1'b0);
    check("sat_drops", drop_cnt, 15);
    step(1'b1, rand_time(), 1'b0);
    step(1'b0, '0, 1'b0);
    check("sat_hold", drop_cnt, 15);
    drain(300);

    // randomized traffic
    apply_reset();
    for (int seg = 0; seg < 9; seg++) begin
      int pd, pr;
      pd = (seg % 3 == 0) ? 5 : ((seg % 3 == 1) ? 30 : 80);
      pr = (seg / 3 == 0) ? 100 : ((seg / 3 == 1) ? 60 : 15);
      for (int i = 0; i < 200; i++)
        step($urandom_range(0, 99) < pd, rand_time(), $urandom_range(0, 99) < pr);
    end
    drain(400);
    check("final_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
